// File: rtl/psum_requant_drain.sv
// rtl/psum_requant_drain.sv - drains partial-sum rows, requantizes them and writes packed activations to the unified buffer
//
// Purpose:
//   After a compute pass, reads NUM_ROWS rows of MATRIX_SIZE signed partial
//   sums from the result memory, requantizes every lane to a DATA_BW-bit
//   signed activation (round-half-up shift, optional ReLU, saturation) and
//   writes the packed rows to consecutive unified-buffer addresses.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             run request, sampled only while idle
//   shift, relu_en,
//   dst_base          run configuration, latched when a start is accepted
//   busy, done        run status; done is a one-cycle pulse at run end
//   sat_count         number of lanes clamped during the current/last run
//   res_rd_en,
//   res_addr,
//   res_rdata         result-memory read port (one-cycle read latency)
//   ub_we, ub_addr,
//   ub_wdata,
//   ub_ready          unified-buffer write port; ub_ready low stalls the drain

module psum_requant_drain #(
    parameter int MATRIX_SIZE    = 64,
    parameter int NUM_ROWS       = 64,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int DATA_BW        = 8,
    parameter int ADDRESSSIZE    = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [4:0]                          shift,
    input  logic                                relu_en,
    input  logic [ADDRESSSIZE-1:0]              dst_base,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         sat_count,
    output logic                                res_rd_en,
    output logic [ADDRESSSIZE-1:0]              res_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_rdata,
    output logic                                ub_we,
    output logic [ADDRESSSIZE-1:0]              ub_addr,
    output logic [DATA_BW*MATRIX_SIZE-1:0]      ub_wdata,
    input  logic                                ub_ready
);

    localparam int PW = PARTIAL_SUM_BW;
    localparam int SW = $clog2(MATRIX_SIZE + 1);
    localparam logic [4:0] MAX_SHIFT = 5'(PW - 1);
    localparam logic [ADDRESSSIZE-1:0] LAST_ROW = ADDRESSSIZE'(NUM_ROWS - 1);
    localparam logic signed [PW:0] QMAX = (PW + 1)'((1 << (DATA_BW - 1)) - 1);
    // ~QMAX == -QMAX-1, the most negative activation
    localparam logic signed [PW:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state;
    logic [4:0]                     shift_l;
    logic                           relu_l;
    logic [ADDRESSSIZE-1:0]         base_l;
    logic [ADDRESSSIZE-1:0]         rd_row;
    logic [ADDRESSSIZE-1:0]         wr_idx;
    logic [ADDRESSSIZE-1:0]         acc_cnt;
    logic                           rd_vld;
    logic                           we_r;
    logic [ADDRESSSIZE-1:0]         addr_r;
    logic [DATA_BW*MATRIX_SIZE-1:0] wdata_r;
    logic [SW-1:0]                  qsat_r;
    logic [15:0]                    sat_cnt;
    logic                           done_r;

    logic                           rd_en;
    logic                           accept;
    logic [DATA_BW*MATRIX_SIZE-1:0] q_data;
    logic [SW-1:0]                  q_sat;
    logic [16:0]                    sat_sum;

    // Reads are throttled by the same ready that advances the pipeline, so a
    // stall freezes the whole drain and the memory keeps its data_out stable.
    assign rd_en     = (state == S_READ) && ub_ready;
    assign accept    = we_r && ub_ready;
    assign sat_sum   = {1'b0, sat_cnt} + 17'(qsat_r);

    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign sat_count = sat_cnt;
    assign res_rd_en = rd_en;
    assign res_addr  = rd_row;
    assign ub_we     = we_r;
    assign ub_addr   = addr_r;
    assign ub_wdata  = wdata_r;

    // Per-lane requantization of the row currently on res_rdata. One extra
    // bit of headroom keeps v + 2^(s-1) from overflowing.
    always_comb begin
        logic signed [PW:0] v;
        logic signed [PW:0] r;
        logic signed [PW:0] half;
        v      = '0;
        r      = '0;
        half   = (PW + 1)'(1) << (shift_l - 5'd1);
        q_data = '0;
        q_sat  = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            v = {res_rdata[i*PW+PW-1], res_rdata[i*PW +: PW]};
            if (shift_l == 5'd0) begin
                r = v;
            end else begin
                r = (v + half) >>> shift_l;
            end
            if (relu_l && (r < 0)) begin
                r = '0;
            end
            if (r > QMAX) begin
                r     = QMAX;
                q_sat = q_sat + SW'(1);
            end else if (r < QMIN) begin
                r     = QMIN;
                q_sat = q_sat + SW'(1);
            end
            q_data[i*DATA_BW +: DATA_BW] = r[DATA_BW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shift_l <= '0;
            relu_l  <= 1'b0;
            base_l  <= '0;
            rd_row  <= '0;
            wr_idx  <= '0;
            acc_cnt <= '0;
            rd_vld  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            qsat_r  <= '0;
            sat_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_READ;
                        shift_l <= (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
                        relu_l  <= relu_en;
                        base_l  <= dst_base;
                        rd_row  <= '0;
                        wr_idx  <= '0;
                        acc_cnt <= '0;
                        sat_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (ub_ready) begin
                        if (rd_row == LAST_ROW) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept && (acc_cnt == LAST_ROW)) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Two-stage pipeline: rd_vld marks res_rdata valid, we_r marks
            // the quantize register valid. Both freeze while ub_ready is low,
            // which holds ub_we/ub_addr/ub_wdata for a stalled write.
            if (ub_ready) begin
                rd_vld <= rd_en;
                we_r   <= rd_vld;
                if (rd_vld) begin
                    wdata_r <= q_data;
                    qsat_r  <= q_sat;
                    addr_r  <= base_l + wr_idx;
                    wr_idx  <= wr_idx + 1'b1;
                end
            end

            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
                sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_psum_requant_drain.sv
// tb/tb_psum_requant_drain.sv - scoreboard bench for psum_requant_drain

module tb_psum_requant_drain;

    localparam int M  = 64;
    localparam int NR = 64;
    localparam int PW = 24;
    localparam int DW = 8;
    localparam int AW = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [4:0]          shift = '0;
    logic                relu_en = 1'b0;
    logic [AW-1:0]       dst_base = '0;
    logic                busy;
    logic                done;
    logic [15:0]         sat_count;
    logic                res_rd_en;
    logic [AW-1:0]       res_addr;
    logic [PW*M-1:0]     res_rdata = '0;
    logic                ub_we;
    logic [AW-1:0]       ub_addr;
    logic [DW*M-1:0]     ub_wdata;
    logic                ub_ready = 1'b1;

    logic [PW*M-1:0]     mem [NR];
    logic [DW*M-1:0]     exp_data [$];
    logic [AW-1:0]       exp_addr [$];
    logic [DW*M-1:0]     cap_data [$];
    logic [AW-1:0]       cap_addr [$];
    int                  exp_sat;
    int                  tests = 0;
    int                  fails = 0;
    int                  done_cnt;
    int                  wr_total = 0;
    int                  wr_at_rst;
    int                  dc;
    logic [DW*M-1:0]     w;

    psum_requant_drain #(
        .MATRIX_SIZE(M), .NUM_ROWS(NR), .PARTIAL_SUM_BW(PW), .DATA_BW(DW), .ADDRESSSIZE(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .shift(shift), .relu_en(relu_en),
        .dst_base(dst_base), .busy(busy), .done(done), .sat_count(sat_count),
        .res_rd_en(res_rd_en), .res_addr(res_addr), .res_rdata(res_rdata),
        .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_ready(ub_ready)
    );

    always #5 clk = ~clk;

    // Result memory: registered read, holds data_out when not enabled.
    always @(posedge clk) begin
        if (res_rd_en) res_rdata <= mem[res_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden lane model using floor division rather than shifts.
    function automatic logic [8:0] qm(input longint v, input int s, input bit relu);
        longint r;
        longint d;
        int     sc;
        bit     sat;
        sc  = (s > 23) ? 23 : s;
        d   = longint'(1) << sc;
        r   = v + d / 2;
        if (r >= 0) r = r / d;
        else        r = -((-r + d - 1) / d);
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 127)  begin r = 127;  sat = 1'b1; end
        if (r < -128) begin r = -128; sat = 1'b1; end
        return {sat, r[7:0]};
    endfunction

    task automatic fill_rows(input int mode);
        logic [31:0] u;
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < M; i++) begin
                u = $urandom;
                if (mode == 0) mem[r][i*PW +: PW] = PW'($signed(u[23:0]) >>> $urandom_range(0, 23));
                else           mem[r][i*PW +: PW] = PW'($urandom_range(0, 200) - 100);
            end
        end
    endtask

    task automatic push_expected();
        logic [DW*M-1:0] row;
        logic [8:0]      q;
        longint          v;
        exp_data.delete();
        exp_addr.delete();
        cap_data.delete();
        cap_addr.delete();
        exp_sat = 0;
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < M; i++) begin
                v = longint'($signed(mem[r][i*PW +: PW]));
                q = qm(v, int'(shift), relu_en);
                row[i*DW +: DW] = q[7:0];
                exp_sat += int'(q[8]);
            end
            exp_data.push_back(row);
            exp_addr.push_back(AW'(dst_base + AW'(r)));
        end
    endtask

    always @(negedge clk) begin
        if (ub_we && ub_ready && !rst) begin
            wr_total++;
            cap_data.push_back(ub_wdata);
            cap_addr.push_back(ub_addr);
            if (exp_data.size() == 0) begin
                chk("unexpected_write", 512'(exp_data.size()), 512'(1));
            end else begin
                chk("wr_addr", 512'(ub_addr), 512'(exp_addr.pop_front()));
                chk("wr_data", ub_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_done"}, 512'(done), 512'(0));
        chk({tag, "_sat"}, 512'(sat_count), 512'(0));
        chk({tag, "_rd_en"}, 512'(res_rd_en), 512'(0));
        chk({tag, "_res_addr"}, 512'(res_addr), 512'(0));
        chk({tag, "_ub_we"}, 512'(ub_we), 512'(0));
        chk({tag, "_ub_addr"}, 512'(ub_addr), 512'(0));
        chk({tag, "_ub_wdata"}, ub_wdata, 512'(0));
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic do_run(input int st_from, input int st_len, input int rst_at,
                          input int mid_at, output int dcyc);
        bit fin;
        fin      = 1'b0;
        dcyc     = -1;
        done_cnt = 0;
        start    = 1'b1;
        ub_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 200 && !fin; c++) begin
            ub_ready = !(c >= st_from && c < st_from + st_len);
            start    = (c == mid_at);
            rst      = (c == rst_at);
            @(negedge clk);
            if (c == 1) chk("busy_c1", 512'(busy), 512'(1));
            if (done) begin
                done_cnt++;
                if (dcyc < 0) begin
                    dcyc = c;
                    chk("busy_at_done", 512'(busy), 512'(1));
                end
            end
            if (dcyc > 0 && c == dcyc + 1) begin
                chk("idle_after_done", 512'(busy), 512'(0));
                fin = 1'b1;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                chk_reset_outputs("after_rst");
                wr_at_rst = wr_total;
            end
            if (rst_at > 0 && c == rst_at + 40) fin = 1'b1;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        rst      = 1'b0;
        ub_ready = 1'b1;
        chk("run_ended", 512'(fin), 512'(1));
    endtask

    task automatic end_checks(input string tag, input int exp_done);
        chk({tag, "_done_cycle"}, 512'(dc), 512'(exp_done));
        chk({tag, "_done_once"}, 512'(done_cnt), 512'(1));
        chk({tag, "_sb_empty"}, 512'(exp_data.size()), 512'(0));
        chk({tag, "_writes"}, 512'(cap_data.size()), 512'(NR));
        chk({tag, "_sat_count"}, 512'(sat_count), 512'(exp_sat));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;

        // basic run
        shift = 5'd8; relu_en = 1'b0; dst_base = '0;
        fill_rows(0);
        mem[0][0*PW +: PW] = 24'd384;
        mem[0][1*PW +: PW] = -24'sd384;
        mem[0][2*PW +: PW] = 24'h7FFFFF;
        push_expected();
        do_run(0, 0, 0, 0, dc);
        end_checks("basic", 67);
        w = cap_data[0];
        chk("basic_lane0", 512'(w[7:0]), 512'(8'd2));
        chk("basic_lane1", 512'(w[15:8]), 512'(8'hFF));
        chk("basic_lane2", 512'(w[23:16]), 512'(8'h7F));
        chk("basic_last_addr", 512'(cap_addr[NR-1]), 512'(63));

        // relu with saturation
        shift = 5'd2; relu_en = 1'b1; dst_base = 10'd5;
        fill_rows(0);
        mem[0][0*PW +: PW] = -24'sd1000;
        mem[0][1*PW +: PW] = 24'd1000;
        push_expected();
        do_run(0, 0, 0, 0, dc);
        end_checks("relu", 67);
        w = cap_data[0];
        chk("relu_neg", 512'(w[7:0]), 512'(8'd0));
        chk("relu_sat", 512'(w[15:8]), 512'(8'd127));

        // shift 0, exactly one saturating lane per row
        shift = 5'd0; relu_en = 1'b0; dst_base = 10'd100;
        fill_rows(1);
        for (int r = 0; r < NR; r++) begin
            mem[r][0*PW +: PW] = 24'd100;
            mem[r][1*PW +: PW] = -24'sd200;
            mem[r][2*PW +: PW] = -24'sd128;
        end
        push_expected();
        do_run(0, 0, 0, 0, dc);
        end_checks("shift0", 67);
        w = cap_data[5];
        chk("shift0_lane0", 512'(w[7:0]), 512'(8'd100));
        chk("shift0_lane1", 512'(w[15:8]), 512'(8'h80));
        chk("shift0_lane2", 512'(w[23:16]), 512'(8'h80));
        chk("shift0_sat64", 512'(sat_count), 512'(64));

        // 5-cycle stall during writes of rows 10..14, oversized shift
        shift = 5'd30; relu_en = 1'b0; dst_base = 10'h200;
        fill_rows(0);
        push_expected();
        do_run(13, 5, 0, 0, dc);
        end_checks("stall", 72);

        // destination address wrap
        shift = 5'd4; relu_en = 1'b1; dst_base = 10'h3F0;
        fill_rows(0);
        push_expected();
        do_run(0, 0, 0, 0, dc);
        end_checks("wrap", 67);
        chk("wrap_addr15", 512'(cap_addr[15]), 512'(10'h3FF));
        chk("wrap_addr16", 512'(cap_addr[16]), 512'(10'h000));

        // reset mid-run abandons the run
        shift = 5'd8; relu_en = 1'b0; dst_base = '0;
        fill_rows(0);
        push_expected();
        do_run(0, 0, 30, 0, dc);
        chk("rst_no_done", 512'(done_cnt), 512'(0));
        chk("rst_no_writes", 512'(wr_total - wr_at_rst), 512'(0));
        exp_data.delete();
        exp_addr.delete();

        // full run after reset, with an ignored mid-run start
        shift = 5'd6; relu_en = 1'b0; dst_base = 10'd64;
        fill_rows(0);
        push_expected();
        do_run(0, 0, 0, 20, dc);
        end_checks("restart", 67);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
